// File: rtl/id_ex_stage_pkg.sv
// Shared 5-stage MIPS pipeline definitions: opcodes, ALU operation classes
// and the control bundle carried from ID through EX/MEM/WB.
package id_ex_stage_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mtorf_sel;
    logic       rfd_sel;
    logic       aluin_sel;
    logic       branch;
    logic       jump;
    logic       rfwe;
    logic       dmwe;
    logic [1:0] alu_op;
  } ctrl_t;

  // A jump decodes BranchD as don't-care; never let it reach EX as a branch.
  function automatic ctrl_t sanitize_ctrl(input ctrl_t c);
    ctrl_t r;
    r        = c;
    r.branch = c.jump ? 1'b0 : c.branch;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is sourced by the
// instruction in ID. Purely combinational so it can be reused for forwarding.
module hazard_detect #(
  parameter int RW = 5
) (
  input  logic          i_valid_e,
  input  logic          i_load_e,
  input  logic [RW-1:0] i_wreg_e,
  input  logic          i_valid_d,
  input  logic [RW-1:0] i_rs_d,
  input  logic [RW-1:0] i_rt_d,
  input  logic          i_reads_rt_d,
  input  logic          i_flush,
  output logic          o_hz,
  output logic          o_stall
);

  logic w_src_match;

  always_comb begin
    w_src_match = (i_wreg_e == i_rs_d) || (i_reads_rt_d && (i_wreg_e == i_rt_d));
    o_hz        = i_valid_e && i_load_e && i_valid_d && (i_wreg_e != '0) && w_src_match;
    // A taken branch squashes the consumer anyway, so no stall is requested.
    o_stall     = o_hz && !i_flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, external stall/flush
// handling and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_d,
  input  logic          MtoRFSelD,
  input  logic          RFDSelD,
  input  logic          ALUInSelD,
  input  logic          BranchD,
  input  logic          JumpD,
  input  logic          RFWED,
  input  logic          DMWED,
  input  logic [1:0]    ALUOpD,
  input  logic [DW-1:0] rd1_d,
  input  logic [DW-1:0] rd2_d,
  input  logic [DW-1:0] simm_d,
  input  logic [RW-1:0] rs_d,
  input  logic [RW-1:0] rt_d,
  input  logic [RW-1:0] rd_d,
  input  logic [DW-1:0] pc4_d,
  input  logic          reads_rt_d,
  input  logic          stall_in,
  input  logic          flush_e,
  output logic          valid_e,
  output logic          MtoRFSelE,
  output logic          RFDSelE,
  output logic          ALUInSelE,
  output logic          BranchE,
  output logic          JumpE,
  output logic          RFWEE,
  output logic          DMWEE,
  output logic [1:0]    ALUOpE,
  output logic [DW-1:0] rd1_e,
  output logic [DW-1:0] rd2_e,
  output logic [DW-1:0] simm_e,
  output logic [DW-1:0] pc4_e,
  output logic [RW-1:0] rs_e,
  output logic [RW-1:0] rt_e,
  output logic [RW-1:0] wreg_e,
  output logic          stall_out,
  output logic [CW-1:0] bubble_cnt
);

  // Flow control: valid_d/valid_e mark real instructions; a register loads when
  // stall_in is low (or flush_e forces a bubble); stall_out asks upstream to
  // hold PC and IF/ID for one cycle while a bubble is inserted here.
  logic          r_valid;
  ctrl_t         r_ctrl;
  logic [DW-1:0] r_rd1, r_rd2, r_simm, r_pc4;
  logic [RW-1:0] r_rs, r_rt, r_wreg;
  logic [CW-1:0] r_cnt;

  ctrl_t         w_ctrl_d;
  logic [RW-1:0] w_wreg_d;
  logic          w_hz;
  logic          w_take;
  logic          w_bubble;

  hazard_detect #(.RW(RW)) u_hazard (
    .i_valid_e    (r_valid),
    .i_load_e     (r_ctrl.mtorf_sel & r_ctrl.rfwe),
    .i_wreg_e     (r_wreg),
    .i_valid_d    (valid_d),
    .i_rs_d       (rs_d),
    .i_rt_d       (rt_d),
    .i_reads_rt_d (reads_rt_d),
    .i_flush      (flush_e),
    .o_hz         (w_hz),
    .o_stall      (stall_out)
  );

  always_comb begin
    w_ctrl_d = sanitize_ctrl('{mtorf_sel: MtoRFSelD, rfd_sel: RFDSelD,
                               aluin_sel: ALUInSelD, branch: BranchD,
                               jump: JumpD, rfwe: RFWED, dmwe: DMWED,
                               alu_op: ALUOpD});
    w_wreg_d = RFWED ? (RFDSelD ? rd_d : rt_d) : '0;
    w_take   = flush_e || !stall_in;
    w_bubble = flush_e || w_hz || !valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_simm  <= '0;
      r_pc4   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_wreg  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_take) begin
        if (w_bubble) begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          r_rd1   <= '0;
          r_rd2   <= '0;
          r_simm  <= '0;
          r_pc4   <= '0;
          r_rs    <= '0;
          r_rt    <= '0;
          r_wreg  <= '0;
        end else begin
          r_valid <= 1'b1;
          r_ctrl  <= w_ctrl_d;
          r_rd1   <= rd1_d;
          r_rd2   <= rd2_d;
          r_simm  <= simm_d;
          r_pc4   <= pc4_d;
          r_rs    <= rs_d;
          r_rt    <= rt_d;
          r_wreg  <= w_wreg_d;
        end
      end
      // Only real load-use bubbles count; held cycles and flushes do not.
      if (!flush_e && !stall_in && w_hz && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    valid_e    = r_valid;
    MtoRFSelE  = r_ctrl.mtorf_sel;
    RFDSelE    = r_ctrl.rfd_sel;
    ALUInSelE  = r_ctrl.aluin_sel;
    BranchE    = r_ctrl.branch;
    JumpE      = r_ctrl.jump;
    RFWEE      = r_ctrl.rfwe;
    DMWEE      = r_ctrl.dmwe;
    ALUOpE     = r_ctrl.alu_op;
    rd1_e      = r_rd1;
    rd2_e      = r_rd2;
    simm_e     = r_simm;
    pc4_e      = r_pc4;
    rs_e       = r_rs;
    rt_e       = r_rt;
    wreg_e     = r_wreg;
    bubble_cnt = r_cnt;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (CW=2 so saturation is reachable) with a
// behavioural model of the EX-stage instruction compared on every negedge.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_d = 1'b0;
  logic          MtoRFSelD = 1'b0, RFDSelD = 1'b0, ALUInSelD = 1'b0, BranchD = 1'b0;
  logic          JumpD = 1'b0, RFWED = 1'b0, DMWED = 1'b0;
  logic [1:0]    ALUOpD = 2'b00;
  logic [DW-1:0] rd1_d = '0, rd2_d = '0, simm_d = '0, pc4_d = '0;
  logic [RW-1:0] rs_d = '0, rt_d = '0, rd_d = '0;
  logic          reads_rt_d = 1'b0, stall_in = 1'b0, flush_e = 1'b0;

  logic          valid_e, MtoRFSelE, RFDSelE, ALUInSelE, BranchE, JumpE, RFWEE, DMWEE;
  logic [1:0]    ALUOpE;
  logic [DW-1:0] rd1_e, rd2_e, simm_e, pc4_e;
  logic [RW-1:0] rs_e, rt_e, wreg_e;
  logic          stall_out;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d),
    .MtoRFSelD(MtoRFSelD), .RFDSelD(RFDSelD), .ALUInSelD(ALUInSelD),
    .BranchD(BranchD), .JumpD(JumpD), .RFWED(RFWED), .DMWED(DMWED),
    .ALUOpD(ALUOpD), .rd1_d(rd1_d), .rd2_d(rd2_d), .simm_d(simm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .pc4_d(pc4_d),
    .reads_rt_d(reads_rt_d), .stall_in(stall_in), .flush_e(flush_e),
    .valid_e(valid_e), .MtoRFSelE(MtoRFSelE), .RFDSelE(RFDSelE),
    .ALUInSelE(ALUInSelE), .BranchE(BranchE), .JumpE(JumpE), .RFWEE(RFWEE),
    .DMWEE(DMWEE), .ALUOpE(ALUOpE), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .simm_e(simm_e), .pc4_e(pc4_e), .rs_e(rs_e), .rt_e(rt_e),
    .wreg_e(wreg_e), .stall_out(stall_out), .bubble_cnt(bubble_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model: what instruction sits in EX ----------------
  typedef struct {
    bit          valid;
    bit          is_load;   // MtoRF and RF write both set
    bit [10:0]   ctl;       // {mtorf,rfd,aluin,branch,jump,rfwe,dmwe,aluop}
    bit [DW-1:0] rd1, rd2, simm, pc4;
    bit [RW-1:0] rs, rt, dest;
  } ex_instr_t;

  ex_instr_t m_ex = '{default: 0};
  int        m_cnt = 0;

  function automatic bit model_hz();
    bit uses;
    uses = (rs_d == m_ex.dest) || (reads_rt_d && rt_d == m_ex.dest);
    return m_ex.valid && m_ex.is_load && valid_d && (m_ex.dest != 0) && uses;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit hz;
    hz = model_hz();
    if (rst) begin
      m_ex = '{default: 0};
      m_cnt = 0;
    end else if (flush_e) begin
      m_ex = '{default: 0};
    end else if (stall_in) begin
      // EX keeps its instruction
    end else if (hz) begin
      m_ex = '{default: 0};
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (!valid_d) begin
      m_ex = '{default: 0};
    end else begin
      m_ex.valid   = 1;
      m_ex.is_load = MtoRFSelD && RFWED;
      m_ex.ctl     = {4'b0, MtoRFSelD, RFDSelD, ALUInSelD, (JumpD ? 1'b0 : BranchD),
                      JumpD, RFWED, DMWED, ALUOpD} >> 4;
      m_ex.ctl     = {MtoRFSelD, RFDSelD, ALUInSelD, (JumpD ? 1'b0 : BranchD),
                      JumpD, RFWED, DMWED, ALUOpD, 2'b00} >> 2;
      m_ex.rd1     = rd1_d;
      m_ex.rd2     = rd2_d;
      m_ex.simm    = simm_d;
      m_ex.pc4     = pc4_d;
      m_ex.rs      = rs_d;
      m_ex.rt      = rt_d;
      m_ex.dest    = !RFWED ? '0 : (RFDSelD ? rd_d : rt_d);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("valid_e", 32'(valid_e), 32'(m_ex.valid));
    chk("ctrl_e", 32'({MtoRFSelE, RFDSelE, ALUInSelE, BranchE, JumpE, RFWEE, DMWEE, ALUOpE}),
        32'(m_ex.ctl[8:0]));
    chk("rd1_e", rd1_e, m_ex.rd1);
    chk("rd2_e", rd2_e, m_ex.rd2);
    chk("simm_e", simm_e, m_ex.simm);
    chk("pc4_e", pc4_e, m_ex.pc4);
    chk("rs_rt_e", 32'({rs_e, rt_e}), 32'({m_ex.rs, m_ex.rt}));
    chk("wreg_e", 32'(wreg_e), 32'(m_ex.dest));
    chk("stall_out", 32'(stall_out), 32'(model_hz() && !flush_e));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drive_id(input bit v, input bit mtorf, input bit rfd, input bit aluin,
                          input bit jump, input bit rfwe, input bit dmwe,
                          input bit [1:0] aluop, input bit [RW-1:0] rs,
                          input bit [RW-1:0] rt, input bit [RW-1:0] rd, input bit rrt);
    valid_d = v; MtoRFSelD = mtorf; RFDSelD = rfd; ALUInSelD = aluin; BranchD = 1'b0;
    JumpD = jump; RFWED = rfwe; DMWED = dmwe; ALUOpD = aluop;
    rs_d = rs; rt_d = rt; rd_d = rd; reads_rt_d = rrt;
    rd1_d = 32'h1000_0000 | 32'(rs); rd2_d = 32'h2000_0000 | 32'(rt);
    simm_d = 32'hFFFF_FF00 | 32'(rd); pc4_d = pc4_d + 32'd4;
  endtask

  task automatic drive_lw(input bit [RW-1:0] dst);
    drive_id(1, 1, 0, 1, 0, 1, 0, 2'b00, 5'd2, dst, 5'd0, 0);
  endtask

  task automatic drive_add(input bit [RW-1:0] rs, input bit [RW-1:0] rt, input bit [RW-1:0] rd);
    drive_id(1, 0, 1, 0, 0, 1, 0, 2'b10, rs, rt, rd, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_sat[5] = '{1, 2, 3, 3, 3};
    pc4_d = 32'h0000_0100;
    #2;
    chk("reset_valid", 32'(valid_e), 0);
    chk("reset_cnt", 32'(bubble_cnt), 0);
    step();
    rst = 1'b0;

    // load-use: lw $8, then add rs=8 rt=3
    drive_lw(5'd8);
    step();
    chk("lw_wreg", 32'(wreg_e), 8);
    chk("lw_mtorf", 32'(MtoRFSelE), 1);
    drive_add(5'd8, 5'd3, 5'd10);
    #1 chk("lu_stall", 32'(stall_out), 1);
    step();
    chk("lu_bubble_valid", 32'(valid_e), 0);
    chk("lu_bubble_cnt", 32'(bubble_cnt), 1);
    chk("lu_stall_drop", 32'(stall_out), 0);
    step();
    chk("lu_add_valid", 32'(valid_e), 1);
    chk("lu_add_aluop", 32'(ALUOpE), 2);
    chk("lu_add_wreg", 32'(wreg_e), 10);

    // lw to $0 never stalls
    drive_lw(5'd0);
    step();
    drive_id(1, 0, 0, 1, 0, 1, 0, 2'b00, 5'd0, 5'd4, 5'd0, 0);
    #1 chk("zero_stall", 32'(stall_out), 0);
    step();
    chk("zero_valid", 32'(valid_e), 1);
    chk("zero_cnt", 32'(bubble_cnt), 1);

    // hazard with flush: flush wins
    drive_lw(5'd8);
    step();
    drive_add(5'd8, 5'd3, 5'd11);
    flush_e = 1'b1;
    #1 chk("flush_stall", 32'(stall_out), 0);
    step();
    flush_e = 1'b0;
    chk("flush_valid", 32'(valid_e), 0);
    chk("flush_cnt", 32'(bubble_cnt), 1);

    // external stall over a hazard holds EX; one bubble after release
    do_reset();
    drive_lw(5'd9);
    step();
    drive_add(5'd1, 5'd9, 5'd12);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_wreg", 32'(wreg_e), 9);
      chk("hold_cnt", 32'(bubble_cnt), 0);
    end
    stall_in = 1'b0;
    step();
    chk("release_bubble", 32'(valid_e), 0);
    chk("release_cnt", 32'(bubble_cnt), 1);
    step();
    chk("release_add", 32'(wreg_e), 12);

    // jump with don't-care BranchD
    do_reset();
    drive_id(1, 0, 0, 0, 1, 0, 0, 2'b00, 5'd0, 5'd5, 5'd0, 0);
    BranchD = 1'bx;
    step();
    BranchD = 1'b0;
    chk("j_jump", 32'(JumpE), 1);
    chk("j_branch", 32'(BranchE), 0);
    chk("j_rfwe", 32'(RFWEE), 0);
    chk("j_wreg", 32'(wreg_e), 0);

    // saturation with CW=2
    for (int k = 0; k < 5; k++) begin
      drive_lw(5'(k + 1));
      step();
      drive_add(5'(k + 1), 5'd0, 5'd20);
      step();
      chk("sat_cnt", 32'(bubble_cnt), exp_sat[k]);
      step();
    end

    // invalid load is a bubble and is not counted
    drive_id(0, 1, 0, 1, 0, 1, 0, 2'b00, 5'd2, 5'd7, 5'd0, 0);
    step();
    chk("inv_valid", 32'(valid_e), 0);
    chk("inv_cnt", 32'(bubble_cnt), 3);

    // asynchronous reset mid-cycle
    drive_add(5'd6, 5'd7, 5'd13);
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_e), 0);
    chk("arst_wreg", 32'(wreg_e), 0);
    chk("arst_rd1", rd1_e, 0);
    chk("arst_cnt", 32'(bubble_cnt), 0);
    #3 rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(valid_e), 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
